// File: rtl/wc_tile_stream_if.sv
// Sample/result stream bundle for wc_tile_stream.
// slave = the tiling block, master = the upstream/downstream environment.
interface wc_tile_stream_if #(
  parameter int DW = 10
) ();
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/wc_tile_stream.sv
// Builds 7-sample tiles (stride 4) for an external WC pipeline and streams its 4 results.
// Optional macro WC_TILE_PAD_EN: zero-pad and process a partial tile ended by s_last.
module wc_tile_stream #(
  parameter int DW  = 10,
  parameter int LAT = 6
) (
  input  logic              clk,
  input  logic              rst,
  wc_tile_stream_if.slave   bus,
  output logic [7*DW-1:0]   wc_d,
  input  logic [4*DW-1:0]   wc_z
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_win [7];
  logic [DW-1:0] r_buf [4];
  logic [2:0]    r_cnt;
  logic [1:0]    r_idx;
  logic [3:0]    r_lcnt;
  logic          r_tlast;
  logic          r_live;
  logic          w_accept;
  logic          w_full;
  logic          w_partial;
  logic          w_fire;
  logic [2:0]    w_cnt_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= FILL;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_inc   = r_cnt + 3'd1;
    w_accept    = 1'b0;
    w_full      = 1'b0;
    w_partial   = 1'b0;
    w_fire      = 1'b0;
    bus.s_ready = 1'b0;
    bus.m_valid = 1'b0;
    bus.m_last  = 1'b0;
    bus.m_data  = r_buf[r_idx];
    case (r_state)
      FILL: begin
        // r_live keeps s_ready low until the first edge after reset release
        bus.s_ready = r_live;
        w_accept    = r_live & bus.s_valid;
        w_full      = w_accept && (w_cnt_inc == 3'd7);
        w_partial   = w_accept && bus.s_last && !w_full;
        if (w_full) w_state_nxt = WAIT;
`ifdef WC_TILE_PAD_EN
        else if (w_partial) w_state_nxt = WAIT;
`endif
      end
      WAIT: begin
        if (r_lcnt == 4'd0) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        bus.m_valid = 1'b1;
        bus.m_last  = r_tlast && (r_idx == 2'd3);
        w_fire      = bus.m_ready;
        if (w_fire && (r_idx == 2'd3)) w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_live  <= 1'b0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_lcnt  <= '0;
      r_tlast <= 1'b0;
      for (int unsigned i = 0; i < 7; i++) r_win[i] <= '0;
      for (int unsigned k = 0; k < 4; k++) r_buf[k] <= '0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_win[r_cnt] <= bus.s_data;
            if (w_full) begin
              r_cnt   <= w_cnt_inc;
              r_lcnt  <= 4'(LAT);
              r_tlast <= bus.s_last;
            end else if (w_partial) begin
`ifdef WC_TILE_PAD_EN
              for (int unsigned i = 0; i < 7; i++)
                if (i > 32'(r_cnt)) r_win[i] <= '0;
              r_cnt   <= 3'd7;
              r_lcnt  <= 4'(LAT);
              r_tlast <= 1'b1;
`else
              r_cnt   <= '0;
`endif
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        WAIT: begin
          if (r_lcnt == 4'd0) begin
            for (int unsigned k = 0; k < 4; k++) r_buf[k] <= wc_z[(3-k)*DW +: DW];
            r_idx <= '0;
          end else begin
            r_lcnt <= r_lcnt - 4'd1;
          end
        end
        DRAIN: begin
          if (w_fire) begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              if (r_tlast) begin
                r_cnt <= '0;
              end else begin
                r_win[0] <= r_win[4];
                r_win[1] <= r_win[5];
                r_win[2] <= r_win[6];
                r_cnt    <= 3'd3;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wc_d = '0;
    for (int unsigned k = 0; k < 7; k++) wc_d[(6-k)*DW +: DW] = r_win[k];
  end

endmodule

// File: tb/tb_wc_tile_stream.sv
// Self-checking bench for wc_tile_stream with a latency-aware WC stand-in and a row-level reference model.
`timescale 1ns/1ps
module tb_wc_tile_stream;
  localparam int DW  = 10;
  localparam int LAT = 6;
`ifdef WC_TILE_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  typedef logic [DW-1:0]   smp_t;
  typedef logic [7*DW-1:0] tile_t;
  typedef logic [4*DW-1:0] res_t;

  localparam tile_t WCD1 = 70'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000;

  logic  clk = 1'b0;
  logic  rst;
  tile_t wc_d;
  res_t  wc_z;
  always #5 clk = ~clk;

  wc_tile_stream_if #(.DW(DW)) bus ();
  wc_tile_stream #(.DW(DW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .wc_d(wc_d), .wc_z(wc_z)
  );

  int checks = 0;
  int errors = 0;
  int tmo    = 0;

  int V1[7] = '{2, -10, 3, 4, -13, -18, -16};
  int R1[4] = '{66, -128, -439, -492};
  int V2[7] = '{-19, -6, 3, -9, -12, 11, -4};
  int R2[4] = '{-138, -246, -114, 150};

  function automatic tile_t pack_tile(input int v[7]);
    tile_t t = '0;
    for (int i = 0; i < 7; i++) t[(6-i)*DW +: DW] = DW'(v[i]);
    return t;
  endfunction

  function automatic res_t pack_res(input int v[4]);
    res_t r = '0;
    for (int i = 0; i < 4; i++) r[(3-i)*DW +: DW] = DW'(v[i]);
    return r;
  endfunction

  // WC stand-in: known reference tiles map to their published results, others to a fixed mix
  function automatic res_t wc_fn(input tile_t t);
    int x[7];
    int r[4];
    if (t == pack_tile(V1)) return pack_res(R1);
    if (t == pack_tile(V2)) return pack_res(R2);
    for (int i = 0; i < 7; i++) x[i] = int'($signed(t[(6-i)*DW +: DW]));
    for (int k = 0; k < 4; k++) r[k] = 3*x[k] - x[k+1] + 2*x[k+3] + k;
    return pack_res(r);
  endfunction

  // Result is only valid once wc_d has been stable for LAT cycles; otherwise garbage
  tile_t       wc_prev;
  int unsigned stab = 0;
  always @(posedge clk) begin
    if (wc_d !== wc_prev) stab <= 0;
    else if (stab < 1000) stab <= stab + 1;
    wc_prev <= wc_d;
  end
  assign wc_z = ((stab + 1 >= LAT) && (wc_d === wc_prev)) ? wc_fn(wc_d) : ~wc_fn(wc_d);

  // Row-level reference: current row samples, expected tiles/results in order
  smp_t  row[$];
  tile_t exp_wcd[$];
  smp_t  exp_dat[$];
  bit    exp_lst[$];

  function automatic void model_accept(input smp_t d, input bit last);
    tile_t t;
    res_t  r;
    row.push_back(d);
    if (row.size() == 7 || last) begin
      if (row.size() == 7 || PAD_EN) begin
        t = '0;
        for (int i = 0; i < row.size(); i++) t[(6-i)*DW +: DW] = row[i];
        r = wc_fn(t);
        exp_wcd.push_back(t);
        for (int k = 0; k < 4; k++) begin
          exp_dat.push_back(r[(3-k)*DW +: DW]);
          exp_lst.push_back(last && (k == 3));
        end
        if (last) row.delete();
        else      row = row[4:6];
      end else begin
        row.delete();
      end
    end
  endfunction

  task automatic push(input smp_t d, input bit last, input int gap);
    int n = 0;
    bus.s_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    while (bus.s_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    if (bus.s_ready !== 1'b1) tmo++;
    else model_accept(d, last);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic pull(input int stall, output smp_t d, output logic l);
    int n = 0;
    bus.m_ready = 1'b0;
    while (bus.m_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    if (bus.m_valid !== 1'b1) tmo++;
    repeat (stall) begin @(posedge clk); #1; end
    d = bus.m_data;
    l = bus.m_last;
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
  endtask

  task automatic do_reset();
    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    row.delete(); exp_wcd.delete(); exp_dat.delete(); exp_lst.delete();
    tmo = 0;
  endtask

  task automatic end_timeouts(input string name);
    checks++;
    if (tmo !== 0) begin errors++; $display("FAIL %s_timeout: %0d handshake waits expired, want 0", name, tmo); end
    tmo = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b want 0", bus.s_ready); end
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b want 0", bus.m_valid); end
    checks++; if (bus.m_data !== '0) begin errors++; $display("FAIL rst_m_data: got %h want 0", bus.m_data); end
    checks++; if (bus.m_last !== 1'b0) begin errors++; $display("FAIL rst_m_last: got %b want 0", bus.m_last); end
    checks++; if (wc_d !== '0) begin errors++; $display("FAIL rst_wc_d: got %h want 0", wc_d); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL rst_release_s_ready: got %b want 1", bus.s_ready); end
  endtask

  task automatic test_spec_vec();
    smp_t d; logic l; int n; bit sr_bad;
    do_reset();
    for (int i = 0; i < 7; i++) push(DW'(V1[i]), i == 6, 0);
    checks++; if (wc_d !== WCD1) begin errors++; $display("FAIL vec1_wc_d: got %h want %h", wc_d, WCD1); end
    n = 0;
    while (bus.m_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    checks++; if (n !== LAT + 1) begin errors++; $display("FAIL vec1_latency: got %0d cycles want %0d", n, LAT + 1); end
    for (int k = 0; k < 4; k++) begin
      pull(0, d, l);
      checks++; if (d !== DW'(R1[k])) begin errors++; $display("FAIL vec1_data%0d: got %0d want %0d", k, $signed(d), R1[k]); end
      checks++; if (l !== (k == 3)) begin errors++; $display("FAIL vec1_last%0d: got %b want %b", k, l, k == 3); end
    end
    for (int i = 0; i < 7; i++) push(DW'(V2[i]), i == 6, 0);
    checks++; if (wc_d !== pack_tile(V2)) begin errors++; $display("FAIL vec2_wc_d: got %h want %h", wc_d, pack_tile(V2)); end
    n = 0; sr_bad = 1'b0;
    while (bus.m_valid !== 1'b1 && n < 50) begin
      if (bus.s_ready !== 1'b0) sr_bad = 1'b1;
      @(posedge clk); #1; n++;
    end
    for (int k = 0; k < 4; k++) begin
      if (bus.s_ready !== 1'b0) sr_bad = 1'b1;
      pull(0, d, l);
      checks++; if (d !== DW'(R2[k])) begin errors++; $display("FAIL vec2_data%0d: got %0d want %0d", k, $signed(d), R2[k]); end
      checks++; if (l !== (k == 3)) begin errors++; $display("FAIL vec2_last%0d: got %b want %b", k, l, k == 3); end
    end
    checks++; if (sr_bad !== 1'b0) begin errors++; $display("FAIL vec2_s_ready_busy: got high during tile, want 0"); end
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL vec2_s_ready_after: got %b want 1", bus.s_ready); end
    end_timeouts("spec_vec");
  endtask

  task automatic test_backpressure();
    smp_t d; logic l; bit seen;
    do_reset();
    for (int i = 0; i < 7; i++) push(DW'(V1[i]), i == 6, 0);
    pull(0, d, l);
    checks++; if (d !== DW'(R1[0])) begin errors++; $display("FAIL bp_data0: got %0d want %0d", $signed(d), R1[0]); end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== DW'(-128) || bus.m_last !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b d=%0d l=%b want v=1 d=-128 l=0", c, bus.m_valid, $signed(bus.m_data), bus.m_last);
      end
      @(posedge clk); #1;
    end
    for (int k = 1; k < 4; k++) begin
      pull($urandom_range(0, 2), d, l);
      checks++; if (d !== DW'(R1[k])) begin errors++; $display("FAIL bp_data%0d: got %0d want %0d", k, $signed(d), R1[k]); end
      checks++; if (l !== (k == 3)) begin errors++; $display("FAIL bp_last%0d: got %b want %b", k, l, k == 3); end
    end
    seen = 1'b0;
    bus.m_ready = 1'b1;
    repeat (10) begin if (bus.m_valid === 1'b1) seen = 1'b1; @(posedge clk); #1; end
    bus.m_ready = 1'b0;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL bp_extra_result: got m_valid after 4 results, want none"); end
    end_timeouts("backpressure");
  endtask

  task automatic drain_tile(input string name, input int max_stall);
    smp_t d; logic l; smp_t ed; bit el;
    for (int k = 0; k < 4; k++) begin
      pull($urandom_range(0, max_stall), d, l);
      ed = exp_dat.pop_front();
      el = exp_lst.pop_front();
      checks++; if (d !== ed) begin errors++; $display("FAIL %s_data%0d: got %h want %h", name, k, d, ed); end
      checks++; if (l !== el) begin errors++; $display("FAIL %s_last%0d: got %b want %b", name, k, l, el); end
    end
  endtask

  task automatic test_sliding();
    smp_t s[11]; tile_t et; bit seen;
    do_reset();
    for (int i = 0; i < 11; i++) s[i] = smp_t'($urandom);
    for (int i = 0; i < 7; i++) push(s[i], 1'b0, $urandom_range(0, 2));
    et = exp_wcd.pop_front();
    checks++; if (wc_d !== et) begin errors++; $display("FAIL slide_tile1_wc_d: got %h want %h", wc_d, et); end
    drain_tile("slide_t1", 2);
    for (int i = 7; i < 11; i++) push(s[i], 1'b0, $urandom_range(0, 2));
    et = exp_wcd.pop_front();
    checks++; if (wc_d !== et) begin errors++; $display("FAIL slide_tile2_wc_d: got %h want %h", wc_d, et); end
    checks++;
    if (wc_d[7*DW-1 -: 3*DW] !== {s[4], s[5], s[6]}) begin
      errors++; $display("FAIL slide_overlap: got %h want %h", wc_d[7*DW-1 -: 3*DW], {s[4], s[5], s[6]});
    end
    drain_tile("slide_t2", 2);
    seen = 1'b0;
    repeat (LAT + 10) begin if (bus.m_valid === 1'b1) seen = 1'b1; @(posedge clk); #1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL slide_third_tile: got m_valid, want exactly 2 tiles"); end
    end_timeouts("sliding");
  endtask

  task automatic test_partial();
    tile_t et; bit seen;
    do_reset();
    for (int i = 0; i < 5; i++) push(smp_t'($urandom), i == 4, 0);
`ifdef WC_TILE_PAD_EN
    et = exp_wcd.pop_front();
    checks++; if (wc_d !== et) begin errors++; $display("FAIL partial_wc_d: got %h want %h", wc_d, et); end
    checks++; if (wc_d[2*DW-1:0] !== '0) begin errors++; $display("FAIL partial_pad: got %h want 0", wc_d[2*DW-1:0]); end
    drain_tile("partial", 1);
`else
    seen = 1'b0;
    repeat (LAT + 10) begin if (bus.m_valid === 1'b1) seen = 1'b1; @(posedge clk); #1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL partial_no_output: got m_valid, want none"); end
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL partial_s_ready: got %b want 1", bus.s_ready); end
`endif
    for (int i = 0; i < 7; i++) push(smp_t'($urandom), i == 6, 0);
    et = exp_wcd.pop_front();
    checks++; if (wc_d !== et) begin errors++; $display("FAIL partial_fresh_wc_d: got %h want %h", wc_d, et); end
    drain_tile("partial_fresh", 1);
    end_timeouts("partial");
  endtask

  task automatic test_reset_wait();
    smp_t d; logic l; bit seen;
    do_reset();
    for (int i = 0; i < 7; i++) push(DW'(V1[i]), i == 6, 0);
    repeat (2) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_data !== '0 || bus.m_last !== 1'b0 || wc_d !== '0) begin
      errors++; $display("FAIL rstwait_outputs: got r=%b v=%b d=%h l=%b wc_d=%h want all 0", bus.s_ready, bus.m_valid, bus.m_data, bus.m_last, wc_d);
    end
    @(posedge clk); #1 rst = 1'b1;
    row.delete(); exp_wcd.delete(); exp_dat.delete(); exp_lst.delete();
    seen = 1'b0;
    repeat (LAT + 8) begin if (bus.m_valid === 1'b1) seen = 1'b1; @(posedge clk); #1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstwait_stale: got m_valid after reset, want none"); end
    for (int i = 0; i < 7; i++) push(DW'(V1[i]), i == 6, 0);
    for (int k = 0; k < 4; k++) begin
      pull(0, d, l);
      checks++; if (d !== DW'(R1[k])) begin errors++; $display("FAIL rstwait_data%0d: got %0d want %0d", k, $signed(d), R1[k]); end
      checks++; if (l !== (k == 3)) begin errors++; $display("FAIL rstwait_last%0d: got %b want %b", k, l, k == 3); end
    end
    end_timeouts("reset_wait");
  endtask

  task automatic test_random();
    int len; tile_t et;
    do_reset();
    for (int r = 0; r < 14; r++) begin
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) begin
        push(smp_t'($urandom), i == len - 1, $urandom_range(0, 1));
        if (exp_wcd.size() != 0) begin
          et = exp_wcd.pop_front();
          checks++; if (wc_d !== et) begin errors++; $display("FAIL rand_wc_d r%0d s%0d: got %h want %h", r, i, wc_d, et); end
          drain_tile("rand", 3);
        end
      end
    end
    end_timeouts("random");
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.m_ready = 1'b0;
    test_reset();
    test_spec_vec();
    test_backpressure();
    test_sliding();
    test_partial();
    test_reset_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wc_tile_stream.md
WC_TILE_STREAM -- requirements
Module: wc_tile_stream

Interface
REQ-001 Parameter DW, default 10, sample and result width in bits (two's complement).
REQ-002 Parameter LAT, default 6, WC pipeline latency in clk cycles from a stable wc_d to a valid wc_z; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (rst=0 resets).
REQ-005 s_valid  input  1  input sample valid.
REQ-006 s_ready  output  1  input sample accepted when s_valid and s_ready are both 1.
REQ-007 s_data  input  DW  input sample.
REQ-008 s_last  input  1  accepted sample is the last sample of a row.
REQ-009 wc_d  output  7*DW  tile to WC; sample 0 (oldest) in bits [7*DW-1:6*DW], sample 6 in [DW-1:0].
REQ-010 wc_z  input  4*DW  WC result; result 0 in bits [4*DW-1:3*DW], result 3 in [DW-1:0].
REQ-011 m_valid  output  1  output result valid.
REQ-012 m_ready  input  1  downstream accepts a result when m_valid and m_ready are both 1.
REQ-013 m_data  output  DW  output result.
REQ-014 m_last  output  1  marks the final result of a row.

Function
REQ-015 The block shall be an FSM with exactly three states: FILL, WAIT and DRAIN.
REQ-016 FILL: s_ready=1, m_valid=0; each accepted sample is written to window slot cnt, and cnt increments (0..7).
REQ-017 FILL->WAIT when cnt reaches 7; wc_d then holds the 7-slot window, and the load counter is set to LAT.
REQ-018 WAIT: s_ready=0, m_valid=0; wc_d is held stable; the counter decrements each cycle; at 0, wc_z is captured into a 4-entry output buffer, then the state is DRAIN.
REQ-019 DRAIN: m_data=buffer[idx] with idx 0..3 (result 0 first), m_valid=1, s_ready=0; idx advances only on a handshake; m_data and m_valid stay stable while m_ready=0.
REQ-020 After the handshake at idx=3 for a tile without last, slots 4..6 shift to slots 0..2, cnt=3, and the state is FILL (stride 4, overlap 3).
REQ-021 If the tile contained the s_last sample, m_last=1 with idx=3 only; after that handshake, cnt=0 and the state is FILL (next row needs 7 fresh samples).
REQ-022 If s_last is accepted on the sample that makes cnt 7, the block shall go directly to WAIT with the tile flagged last.
REQ-023 Results are passed through unmodified, DW bits each; the block performs no arithmetic on samples or results.
REQ-024 Minimum cycles per tile = new samples + LAT + 1 capture + 4 drain cycles; there is no overlap between FILL and DRAIN.

Reset
REQ-025 While rst=0: state=FILL, cnt=0, idx=0, window and output buffer zeroed, wc_d=0, s_ready=0, m_valid=0, m_data=0, m_last=0.
REQ-026 s_ready shall go to 1 on the first clk edge after rst is released.
REQ-027 Reset mid-WAIT or mid-DRAIN discards the in-flight tile and its results; no m_valid is seen after release until a new tile completes.

Configuration
REQ-028 Macro WC_TILE_PAD_EN controls the handling of a partial tile, i.e. s_last accepted with cnt<7 after the increment.
REQ-029 With WC_TILE_PAD_EN defined: the remaining slots are zero-filled, the state goes to WAIT, all 4 results are emitted, and m_last is set on result 3.
REQ-030 Without WC_TILE_PAD_EN: the partial window is discarded, cnt=0, the state stays FILL, no results are emitted, and that row produces no m_last.

Verification
REQ-031 The bench shall connect the WC model: stream 2,-10,3,4,-13,-18,-16 with s_last on -16 and m_ready=1 -> wc_d=0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000; after LAT+1 cycles, m_data=66,-128,-439,-492, with m_last only on -492.
REQ-032 After REQ-031, stream -19,-6,3,-9,-12,11,-4 with s_last -> m_data=-138,-246,-114,150; s_ready=0 from acceptance of -4 until the handshake of 150.
REQ-033 Backpressure: hold m_ready=0 for 5 cycles at idx=1 of a tile -> m_data stays -128 and m_valid stays 1; no result is lost or duplicated.
REQ-034 Sliding: stream 11 samples without last -> exactly 2 tiles; tile 2 wc_d slots 0..2 equal samples 4..6 of tile 1.
REQ-035 Partial: 5 samples with s_last -> with WC_TILE_PAD_EN, slots 5..6 of wc_d are 0 and 4 results are emitted with m_last; without it, no m_valid and cnt=0.
REQ-036 Assert rst=0 during WAIT -> all outputs are 0 immediately; a fresh 7-sample row then yields the correct REQ-031 results.
